aes_inv_sub_bytes_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 22 ++
 rtl/inv_sbox.sv | 32 +++
 rtl/aes_inv_sub_bytes_iter.sv | 94 +++++++++
 tb/tb_aes_inv_sub_bytes_iter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: FIPS-197 byte slicing and legal lane counts.
// Byte 0 of a block is its most significant byte.
package aes_pkg;
   localparam int AES_BLOCK_W   = 128;
   localparam int AES_BYTE_W    = 8;
   localparam int AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } isb_state_t;

   // Low bit of byte idx within a block: byte i lives at [127-8i -: 8].
   function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
      return 7'(AES_BLOCK_W - AES_BYTE_W) - {idx, 3'b000};
   endfunction

   function automatic bit legal_bpc(input int bpc);
      return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
   endfunction
endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, purely combinational 8-bit lookup (FIPS-197 table).
// Zero latency; no flow control.
module inv_sbox
   import aes_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] val,
   output logic [AES_BYTE_W-1:0] inv
);
   localparam logic [7:0] INV_TBL [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   always_comb begin
      inv = 8'h00;
      inv = INV_TBL[val];
   end
endmodule

// File: rtl/aes_inv_sub_bytes_iter.sv
// Iterative InvSubBytes: BYTES_PER_CYCLE inverse S-box lookups per clock, result valid 16/BPC cycles after accept.
// One block in flight: in_ready only in IDLE, result held in DONE until out_ready.
module aes_inv_sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data,
   output logic                   busy
);
   localparam int NUM_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
   localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

   if (!legal_bpc(BYTES_PER_CYCLE)) begin : g_bad_bpc
      $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   isb_state_t             state;
   logic [CNT_W-1:0]       cnt;
   logic [AES_BLOCK_W-1:0] data;
   logic [AES_BLOCK_W-1:0] data_sub;
   logic [3:0]             lane_idx [BYTES_PER_CYCLE];
   logic [AES_BYTE_W-1:0]  lane_val [BYTES_PER_CYCLE];
   logic [AES_BYTE_W-1:0]  lane_inv [BYTES_PER_CYCLE];

   // Lane j works on byte cnt*BPC+j; the 4-bit index keeps the mux inside the block.
   for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
      assign lane_idx[j] = 4'(int'(cnt) * BYTES_PER_CYCLE + j);
      assign lane_val[j] = data[byte_lsb(lane_idx[j]) +: AES_BYTE_W];

      inv_sbox u_inv_sbox (
         .val (lane_val[j]),
         .inv (lane_inv[j])
      );
   end

   always_comb begin
      data_sub = data;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         data_sub[byte_lsb(lane_idx[j]) +: AES_BYTE_W] = lane_inv[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         data  <= '0;
      end else if (clear) begin
         // Abort keeps the data register; only control state is dropped.
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  data  <= in_data;
                  cnt   <= '0;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               data <= data_sub;
               if (cnt == LAST_STEP) begin
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE) && !clear;
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign out_data  = data;
endmodule

// File: tb/tb_aes_inv_sub_bytes_iter.sv
// Bench for aes_inv_sub_bytes_iter: one instance per legal BYTES_PER_CYCLE, all on one clock.
// Reference S-boxes are derived from GF(2^8) inversion plus the AES affine map.
module tb_aes_inv_sub_bytes_iter;
   localparam int NI = 5;

   logic         clk;
   logic         rst_n     [NI];
   logic         clear     [NI];
   logic         in_valid  [NI];
   logic         in_ready  [NI];
   logic [127:0] in_data   [NI];
   logic         out_valid [NI];
   logic         out_ready [NI];
   logic [127:0] out_data  [NI];
   logic         busy      [NI];

   int total = 0;
   int bad = 0;
   int edge_cnt = 0;

   logic [7:0]   fwd  [256];
   logic [7:0]   invt [256];

   bit           m_pend [NI];
   int           m_acc  [NI];
   logic [127:0] m_dat  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      aes_inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) dut (
         .clk       (clk),
         .rst_n     (rst_n[g]),
         .clear     (clear[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .busy      (busy[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_ref();
      logic [7:0] b;
      logic [7:0] s;
      for (int v = 0; v < 256; v++) begin
         b = 8'h00;
         for (int w = 1; w < 256; w++) begin
            if (gmul(8'(v), 8'(w)) == 8'h01) b = 8'(w);
         end
         s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
         fwd[v] = s;
         invt[s] = 8'(v);
      end
   endtask

   function automatic logic [127:0] inv_state(input logic [127:0] d);
      logic [127:0] r;
      r = '0;
      for (int b = 0; b < 16; b++) r[127 - 8 * b -: 8] = invt[d[127 - 8 * b -: 8]];
      return r;
   endfunction

   task automatic chk(input string name, input int i, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s bpc=%0d got=%h want=%h t=%0t", name, 1 << i, act, exp, $time);
      end
   endtask

   // Per-cycle model: a pending block turns valid NUM_STEPS edges after its accept edge.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         bit ev;
         if (!rst_n[i]) m_pend[i] = 1'b0;
         ev = m_pend[i] && (edge_cnt >= m_acc[i] + (16 >> i));
         chk("out_valid", i, out_valid[i], ev);
         chk("busy", i, busy[i], m_pend[i]);
         chk("in_ready", i, in_ready[i], !m_pend[i] && !clear[i]);
         if (!rst_n[i]) chk("reset_out_data", i, out_data[i], '0);
         else if (ev) chk("out_data", i, out_data[i], m_dat[i]);
         if (!rst_n[i]) begin
         end else if (clear[i]) begin
            m_pend[i] = 1'b0;
         end else if (ev && out_ready[i]) begin
            m_pend[i] = 1'b0;
         end else if (!m_pend[i] && in_valid[i]) begin
            m_pend[i] = 1'b1;
            m_acc[i]  = edge_cnt + 1;
            m_dat[i]  = inv_state(in_data[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [127:0] d, output int acc);
      acc = -1;
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      for (int c = 0; c < 200; c++) begin
         if (in_ready[i] === 1'b1) begin
            tick();
            acc = edge_cnt;
            in_valid[i] = 1'b0;
            return;
         end
         tick();
      end
      in_valid[i] = 1'b0;
      chk("send_timeout", i, 1, 0);
   endtask

   task automatic recv(input int i, output logic [127:0] d, output int e);
      d = '0;
      e = -1;
      for (int c = 0; c < 200; c++) begin
         if (out_valid[i] === 1'b1) begin
            d = out_data[i];
            e = edge_cnt;
            return;
         end
         tick();
      end
      chk("recv_timeout", i, 1, 0);
   endtask

   task automatic run_inst(input int i);
      int n;
      int acc;
      int e;
      int prev;
      logic [127:0] d;
      logic [127:0] x;
      logic [127:0] s;
      logic [7:0] tin  [4] = '{8'h52, 8'h16, 8'h63, 8'h00};
      logic [7:0] texp [4] = '{8'h48, 8'hff, 8'h00, 8'h52};
      n = 16 >> i;
      out_ready[i] = 1'b1;
      if (i == 2) begin
         send(i, 128'h637c777bf26b6fc53001672bfed7ab76, acc);
         recv(i, d, e);
         chk("kat_data", i, d, 128'h000102030405060708090a0b0c0d0e0f);
         chk("kat_latency", i, 128'(e - acc), 128'(n));
         tick();
         // Stall in DONE with a competing in_valid that must be ignored.
         out_ready[i] = 1'b0;
         send(i, {16{8'h16}}, acc);
         recv(i, d, e);
         chk("bp_data", i, d, {16{8'hff}});
         in_valid[i] = 1'b1;
         in_data[i]  = 128'h0123456789abcdef0123456789abcdef;
         repeat (10) tick();
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         tick();
         chk("bp_release", i, {busy[i], in_ready[i]}, 2'b01);
         // Abort during step 2, then offer a block while clear is still high.
         send(i, {16{8'h52}}, acc);
         tick();
         tick();
         clear[i] = 1'b1;
         tick();
         in_valid[i] = 1'b1;
         in_data[i]  = {16{8'h63}};
         #1;
         chk("clear_in_ready", i, in_ready[i], 0);
         tick();
         clear[i]    = 1'b0;
         in_valid[i] = 1'b0;
         #1;
         chk("clear_no_accept", i, busy[i], 0);
         // Asynchronous reset in the middle of a block.
         send(i, {16{8'h63}}, acc);
         tick();
         rst_n[i] = 1'b0;
         #1;
         chk("rst_flags", i, {out_valid[i], busy[i], in_ready[i]}, 3'b001);
         chk("rst_data", i, out_data[i], '0);
         tick();
         rst_n[i] = 1'b1;
         tick();
      end
      if (i == 0) begin
         for (int t = 0; t < 4; t++) begin
            send(i, {16{tin[t]}}, acc);
            recv(i, d, e);
            chk("edge_data", i, d, {16{texp[t]}});
            chk("edge_latency", i, 128'(e - acc), 128'(n));
         end
      end
      // Round trip; a block occupies IDLE + NUM_STEPS BUSY + DONE cycles.
      prev = 0;
      for (int v = 0; v < 1000; v++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         for (int b = 0; b < 16; b++) s[127 - 8 * b -: 8] = fwd[x[127 - 8 * b -: 8]];
         send(i, s, acc);
         if (v > 0) chk("b2b_spacing", i, 128'(acc - prev), 128'(n + 2));
         prev = acc;
         recv(i, d, e);
         chk("rt_data", i, d, x);
         chk("rt_latency", i, 128'(e - acc), 128'(n));
      end
      tick();
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst_n[i]     = 1'b0;
         clear[i]     = 1'b0;
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
         in_data[i]   = '0;
      end
      build_ref();
      repeat (3) tick();
      for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
      tick();
      fork
         run_inst(0);
         run_inst(1);
         run_inst(2);
         run_inst(3);
         run_inst(4);
      join
      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
